pipe_stage_chain: RTL



---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_stage_cell.sv | 33 +++
 rtl/pipe_stage_chain.sv | 74 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control encoding, depth limit and ID/EX payload layout for pipe_stage_chain users.
package pipe_pkg;
  localparam int PIPE_MAX_DEPTH = 8;
  typedef enum logic [2:0] {CTRL_RESET, CTRL_FLUSH, CTRL_HOLD, CTRL_BUBBLE, CTRL_RUN} ctrl_e;
  localparam int IR_W       = 32;
  localparam int PC4_W      = 32;
  localparam int RS_W       = 32;
  localparam int RT_W       = 32;
  localparam int EXT_W      = 32;
  localparam int LW_W       = 1;
  localparam int R_T_W      = 1;
  localparam int GRF_WE_W   = 1;
  localparam int GRF_REG_W  = 5;
  localparam int IR_OFF     = 0;
  localparam int PC4_OFF    = IR_OFF + IR_W;
  localparam int RS_OFF     = PC4_OFF + PC4_W;
  localparam int RT_OFF     = RS_OFF + RS_W;
  localparam int EXT_OFF    = RT_OFF + RT_W;
  localparam int LW_OFF     = EXT_OFF + EXT_W;
  localparam int R_T_OFF    = LW_OFF + LW_W;
  localparam int GRF_WE_OFF = R_T_OFF + R_T_W;
  localparam int GRF_RS_OFF = GRF_WE_OFF + GRF_WE_W;
  localparam int GRF_RT_OFF = GRF_RS_OFF + GRF_REG_W;
  localparam int GRF_RD_OFF = GRF_RT_OFF + GRF_REG_W;
  localparam int IDEX_W     = GRF_RD_OFF + GRF_REG_W;
  function automatic ctrl_e ctrl_decode(input logic reset, input logic flush, input logic hold, input logic bubble);
    return reset ? CTRL_RESET : flush ? CTRL_FLUSH : hold ? CTRL_HOLD : bubble ? CTRL_BUBBLE : CTRL_RUN;
  endfunction
  function automatic logic [3:0] popcnt(input logic [PIPE_MAX_DEPTH-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < PIPE_MAX_DEPTH; i++) n = n + 4'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/pipe_stage_cell.sv
// pipe_stage_cell: one valid+payload register; kill beats load, neither means keep.
module pipe_stage_cell #(
  parameter int DATA_W       = 32,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              kill,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  always_comb begin
    valid_d = kill ? 1'b0 : load ? valid_i : valid_q;
    data_d  = kill ? (ZERO_INVALID ? '0 : data_q)
            : load ? ((ZERO_INVALID && !valid_i) ? '0 : data_i) : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage valid+payload pipeline with hold/flush/bubble controls.
// Define PIPE_STAGE_PERF_EN to add hold/bubble/flush-kill event counters.
module pipe_stage_chain import pipe_pkg::*; #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              bubble,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DEPTH-1:0]  valid_vec,
  output logic              busy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       hold_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_kill_cnt
`endif
);
  ctrl_e             ctrl;
  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  assign ctrl = ctrl_decode(reset, flush, hold, bubble);
  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH out of range");
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              vin, kill, load;
    logic [DATA_W-1:0] din;
    if (k == 0) begin : g_head
      // a bubble kills only the entry stage; later stages keep advancing
      assign vin  = valid_i;
      assign din  = data_i;
      assign kill = ctrl == CTRL_FLUSH || ctrl == CTRL_BUBBLE;
      assign load = ctrl == CTRL_RUN;
    end else begin : g_body
      assign vin  = valid_q[k-1];
      assign din  = data_q[k-1];
      assign kill = ctrl == CTRL_FLUSH;
      assign load = ctrl == CTRL_RUN || ctrl == CTRL_BUBBLE;
    end
    pipe_stage_cell #(.DATA_W(DATA_W), .ZERO_INVALID(ZERO_INVALID)) u_cell (
      .clk(clk), .reset(reset), .load(load), .kill(kill),
      .valid_i(vin), .data_i(din), .valid_o(valid_q[k]), .data_o(data_q[k])
    );
  end
  assign valid_vec = valid_q;
  assign valid_o   = valid_q[DEPTH-1];
  assign data_o    = data_q[DEPTH-1];
  assign busy      = |valid_q;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] hold_cnt_q, bubble_cnt_q, kill_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q   <= '0;
      bubble_cnt_q <= '0;
      kill_cnt_q   <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_q + 32'(ctrl == CTRL_HOLD);
      bubble_cnt_q <= bubble_cnt_q + 32'(ctrl == CTRL_BUBBLE);
      kill_cnt_q   <= kill_cnt_q + ((ctrl == CTRL_FLUSH) ? 32'(popcnt(PIPE_MAX_DEPTH'(valid_q))) : 32'd0);
    end
  end
  assign hold_cnt       = hold_cnt_q;
  assign bubble_cnt     = bubble_cnt_q;
  assign flush_kill_cnt = kill_cnt_q;
`endif
endmodule
